// File: rtl/lod_trunc_pipe.sv
// Multi-lane leading-one detect and window truncation with optional round-half-up.
// Two-stage valid/ready pipeline: stage A finds the leading one, stage B forms the window.
module lod_trunc_pipe #(
  parameter int BW      = 8,
  parameter int MULT_DW = 5,
  parameter int LANES   = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [LANES*BW-1:0]                 in_data,
  input  logic                                in_rnd,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [LANES*(MULT_DW-2)-1:0]        out_mant,
  output logic [LANES*$clog2(BW)-1:0]         out_pos,
  output logic [LANES-1:0]                    out_exact,
  output logic [LANES-1:0]                    out_nz,
  input  logic                                sat_clr,
  output logic [15:0]                         sat_count
);

  localparam int W   = MULT_DW - 2;
  localparam int PW  = $clog2(BW);
  localparam int NSW = $clog2(LANES + 1);

  typedef struct packed {
    logic          sat;
    logic [PW-1:0] pos;
    logic [W-1:0]  mant;
  } lane_res_t;

  function automatic logic [PW-1:0] lod(input logic [BW-1:0] x);
    lod = '0;
    for (int i = 0; i < BW; i++) begin
      if (x[i]) lod = PW'(i);
    end
  endfunction

  // Window below the leading one, then round-half-up with carry into the next
  // position or saturation when the leading one is already the top bit.
  function automatic lane_res_t round_lane(input logic [BW-1:0] x, input logic [PW-1:0] p,
                                           input logic exact, input logic rnd);
    logic [BW-1:0] sh;
    logic [W:0]    sum;
    round_lane.sat  = 1'b0;
    round_lane.pos  = p;
    round_lane.mant = '0;
    sh  = x >> (int'(p) - W - 1);
    sum = {1'b0, sh[W:1]} + {{W{1'b0}}, sh[0]};
    if (!exact) begin
      if (!rnd) begin
        round_lane.mant = sh[W:1];
      end else if (!sum[W]) begin
        round_lane.mant = sum[W-1:0];
      end else if (int'(p) + 1 < BW) begin
        round_lane.mant = '0;
        round_lane.pos  = p + PW'(1);
      end else begin
        round_lane.mant = '1;
        round_lane.pos  = PW'(BW - 1);
        round_lane.sat  = 1'b1;
      end
    end
  endfunction

  logic                   vld_p0_q, vld_p1_q;
  logic                   adv_a, adv_b, ld_a, ld_b;
  logic [LANES*BW-1:0]    x_p0_q;
  logic                   rnd_p0_q;
  logic [LANES*PW-1:0]    pos_p0_q, pos_p0_d;
  logic [LANES-1:0]       nz_p0_q, nz_p0_d, exact_p0_q, exact_p0_d;
  logic [LANES*W-1:0]     out_mant_q, out_mant_d;
  logic [LANES*PW-1:0]    out_pos_q, out_pos_d;
  logic [LANES-1:0]       out_exact_q, out_nz_q;
  logic [NSW-1:0]         nsat_d;
  logic [16:0]            sat_sum;
  logic [15:0]            sat_count_q, sat_count_d;
  lane_res_t              res;

  assign adv_b    = !vld_p1_q | out_ready;
  assign adv_a    = !vld_p0_q | adv_b;
  assign in_ready = adv_a;
  assign ld_a     = in_valid & adv_a;
  assign ld_b     = vld_p0_q & adv_b;

  // Stage A: leading-one detect
  always_comb begin
    pos_p0_d   = '0;
    nz_p0_d    = '0;
    exact_p0_d = '0;
    for (int l = 0; l < LANES; l++) begin
      pos_p0_d[l*PW +: PW] = lod(in_data[l*BW +: BW]);
      nz_p0_d[l]           = |in_data[l*BW +: BW];
      exact_p0_d[l]        = int'(lod(in_data[l*BW +: BW])) < MULT_DW;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_a) begin
      x_p0_q     <= in_data;
      rnd_p0_q   <= in_rnd;
      pos_p0_q   <= pos_p0_d;
      nz_p0_q    <= nz_p0_d;
      exact_p0_q <= exact_p0_d;
    end
  end

  // Stage B: window, rounding and saturation accounting
  always_comb begin
    out_mant_d = '0;
    out_pos_d  = '0;
    nsat_d     = '0;
    res        = '0;
    for (int l = 0; l < LANES; l++) begin
      res = round_lane(x_p0_q[l*BW +: BW], pos_p0_q[l*PW +: PW], exact_p0_q[l], rnd_p0_q);
      out_mant_d[l*W +: W]  = res.mant;
      out_pos_d[l*PW +: PW] = res.pos;
      nsat_d                = nsat_d + NSW'(res.sat);
    end
  end

  assign sat_sum = {1'b0, sat_count_q} + 17'(nsat_d);

  always_comb begin
    sat_count_d = sat_count_q;
    if (sat_clr) sat_count_d = '0;
    else if (ld_b) sat_count_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0_q    <= 1'b0;
      vld_p1_q    <= 1'b0;
      out_mant_q  <= '0;
      out_pos_q   <= '0;
      out_exact_q <= '0;
      out_nz_q    <= '0;
      sat_count_q <= '0;
    end else begin
      if (adv_a) vld_p0_q <= in_valid;
      if (adv_b) vld_p1_q <= vld_p0_q;
      if (ld_b) begin
        out_mant_q  <= out_mant_d;
        out_pos_q   <= out_pos_d;
        out_exact_q <= exact_p0_q;
        out_nz_q    <= nz_p0_q;
      end
      sat_count_q <= sat_count_d;
    end
  end

  assign out_valid = vld_p1_q;
  assign out_mant  = out_mant_q;
  assign out_pos   = out_pos_q;
  assign out_exact = out_exact_q;
  assign out_nz    = out_nz_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_lod_trunc_pipe.sv
// Scoreboard bench for lod_trunc_pipe: expected results are queued on acceptance
// and compared by an independent monitor when the unit presents an output.
module tb_lod_trunc_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_rnd = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] out_mant;
  logic [11:0] out_pos;
  logic [3:0]  out_exact;
  logic [3:0]  out_nz;
  logic        sat_clr = 1'b0;
  logic [15:0] sat_count;

  lod_trunc_pipe #(.BW(8), .MULT_DW(5), .LANES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_rnd(in_rnd), .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_pos(out_pos), .out_exact(out_exact), .out_nz(out_nz),
    .sat_clr(sat_clr), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] mant;
    logic [11:0] pos;
    logic [3:0]  exact;
    logic [3:0]  nz;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   exp_sat = 0;
  bit   cur_lat = 0;
  bit   ovr_en = 0;
  exp_t ovr_exp;
  bit   rand_rdy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: floor(log2 x), window below it, then round-half-up on the next bit.
  function automatic void model(input logic [31:0] d, input bit r, output exp_t e, output int ns);
    ns = 0;
    e.mant = '0; e.pos = '0; e.exact = '0; e.nz = '0; e.cyc = 0; e.lat = 0;
    for (int l = 0; l < 4; l++) begin
      int x, p, m, rb;
      x = int'(d[l*8 +: 8]);
      p = 0;
      for (int i = 1; i < 8; i++) if (x >= (1 << i)) p = i;
      e.nz[l] = (x != 0);
      m = 0;
      if (p < 5) begin
        e.exact[l] = 1'b1;
      end else begin
        e.exact[l] = 1'b0;
        m  = (x >> (p - 3)) % 8;
        rb = (x >> (p - 4)) % 2;
        if (r) begin
          m = m + rb;
          if (m == 8) begin
            if (p + 1 < 8) begin m = 0; p = p + 1; end
            else begin m = 7; ns++; end
          end
        end
      end
      e.mant[l*3 +: 3] = 3'(m);
      e.pos[l*3 +: 3]  = 3'(p);
    end
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    int   ns;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", {32'd0, out_mant, out_pos, out_exact, out_nz}, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("mant", 64'(out_mant), 64'(e.mant));
          chk("pos", 64'(out_pos), 64'(e.pos));
          chk("exact", 64'(out_exact), 64'(e.exact));
          chk("nz", 64'(out_nz), 64'(e.nz));
          if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'd2);
          pop_cyc.push_back(cyc);
        end
      end
      if (in_valid && in_ready) begin
        model(in_data, in_rnd, e, ns);
        exp_sat = (exp_sat + ns > 65535) ? 65535 : exp_sat + ns;
        if (ovr_en) begin
          e.mant = ovr_exp.mant; e.pos = ovr_exp.pos;
          e.exact = ovr_exp.exact; e.nz = ovr_exp.nz;
        end
        e.cyc = cyc;
        e.lat = cur_lat;
        sb.push_back(e);
      end
    end
  end

  task automatic send(input logic [31:0] d, input bit r, input bit lat);
    bit acc = 0;
    int k = 0;
    in_data = d; in_rnd = r; in_valid = 1'b1; cur_lat = lat;
    if (rand_rdy) out_ready = ($urandom % 4) != 0;
    while (!acc && k < 2000) begin
      @(negedge clk);
      acc = in_ready;
      k++;
      if (!acc) begin
        @(posedge clk); #1;
        if (rand_rdy) out_ready = ($urandom % 4) != 0;
      end
    end
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    out_ready = 1'b1; in_valid = 1'b0; rand_rdy = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("drain_pending", 64'(sb.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rnd_byte();
    case ($urandom % 4)
      0: return 8'($urandom);
      1: return 8'hF0 | 8'($urandom % 16);
      2: return 8'($urandom % 32);
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    logic [63:0] snap;
    int acc;
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] snap;
    int          acc;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_sat_count", 64'(sat_count), 64'd0);
    chk("rst_outs", {32'd0, out_mant, out_pos, out_exact, out_nz}, 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Directed truncation vector
    ovr_en = 1;
    ovr_exp.mant = 12'h03B; ovr_exp.pos = 12'h137; ovr_exp.exact = 4'b1100; ovr_exp.nz = 4'b0111;
    send(32'h0013_78B6, 1'b0, 1'b1);
    ovr_en = 0;
    drain();

    // Directed rounding vector: round up, carry into new position, saturation
    ovr_en = 1;
    ovr_exp.mant = 12'h1C4; ovr_exp.pos = 12'h9FF; ovr_exp.exact = 4'b1000; ovr_exp.nz = 4'b1111;
    send(32'h1FF8_7CBE, 1'b1, 1'b1);
    ovr_en = 0;
    drain();
    chk("sat_after_round", 64'(sat_count), 64'd1);

    // Back-to-back stream, no bubbles
    pop_cyc.delete();
    for (int i = 0; i < 8; i++) send({rnd_byte(), rnd_byte(), rnd_byte(), rnd_byte()}, 1'($urandom), 1'b1);
    drain();
    chk("b2b_count", 64'(pop_cyc.size()), 64'd8);
    if (pop_cyc.size() == 8) chk("b2b_span", 64'(pop_cyc[7] - pop_cyc[0]), 64'd7);

    // Stall mid-stream behind a bubble in stage A
    for (int i = 0; i < 3; i++) send({rnd_byte(), rnd_byte(), rnd_byte(), rnd_byte()}, 1'($urandom), 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; cur_lat = 0;
    in_data = {rnd_byte(), rnd_byte(), rnd_byte(), rnd_byte()}; in_rnd = 1'($urandom);
    acc = 0;
    snap = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        snap = {31'd0, out_valid, out_mant, out_pos, out_exact, out_nz};
      end else begin
        chk("stall_frozen", {31'd0, out_valid, out_mant, out_pos, out_exact, out_nz}, snap);
      end
      if (in_ready) acc++;
      @(posedge clk); #1;
      if (in_ready == 1'b0 && acc > 0 && i == 0) begin
        in_data = {rnd_byte(), rnd_byte(), rnd_byte(), rnd_byte()}; in_rnd = 1'($urandom);
      end
    end
    chk("stall_accepts", 64'(acc), 64'd1);
    out_ready = 1'b1;
    send(in_data, in_rnd, 1'b0);
    drain();

    // Randomized traffic with random backpressure
    for (int i = 0; i < 200; i++) begin
      rand_rdy = 1;
      send({rnd_byte(), rnd_byte(), rnd_byte(), rnd_byte()}, 1'($urandom), 1'b0);
      repeat ($urandom % 3) begin
        @(posedge clk); #1;
        out_ready = ($urandom % 4) != 0;
      end
    end
    drain();
    chk("sat_after_random", 64'(sat_count), 64'(exp_sat));

    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    exp_sat = 0;
    chk("sat_clr_idle", 64'(sat_count), 64'd0);

    // Saturating counter ceiling
    for (int i = 0; i < 16383; i++) send(32'hF8F8_F8F8, 1'b1, 1'b0);
    send(32'h00F8_F8F8, 1'b1, 1'b0);
    drain();
    chk("sat_ffff", 64'(sat_count), 64'(exp_sat));
    chk("sat_ffff_const", 64'(sat_count), 64'hFFFF);
    send(32'h0000_00F8, 1'b1, 1'b0);
    drain();
    chk("sat_hold_ffff", 64'(sat_count), 64'hFFFF);

    // Clear wins over a same-cycle saturation event
    send(32'h0000_00F8, 1'b1, 1'b0);
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    exp_sat = 0;
    drain();
    chk("sat_clr_priority", 64'(sat_count), 64'd0);

    // Asynchronous reset with both stages full
    send(32'h0000_00F8, 1'b1, 1'b0);
    drain();
    chk("sat_before_rst", 64'(sat_count), 64'd1);
    out_ready = 1'b0;
    send(32'h1234_5678, 1'b0, 1'b0);
    send(32'hF8F8_F8F8, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_sat_count", 64'(sat_count), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_outs", {32'd0, out_mant, out_pos, out_exact, out_nz}, 64'd0);
    sb.delete();
    exp_sat = 0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    ovr_en = 1;
    ovr_exp.mant = 12'h03B; ovr_exp.pos = 12'h137; ovr_exp.exact = 4'b1100; ovr_exp.nz = 4'b0111;
    send(32'h0013_78B6, 1'b0, 1'b1);
    ovr_en = 0;
    drain();
    chk("sat_after_rst", 64'(sat_count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lod_trunc_pipe.md
# lod_trunc_pipe

Pipelined, multi-lane leading-one-detect and window-truncation unit for the approximate multiplier datapath. Each lane takes a BW-bit unsigned operand, finds its leading one, and emits the W = MULT_DW-2 bits directly below it, optionally rounded, together with the leading-one position. It replaces the combinational window mux in front of the approximate multiplier array. It adds a valid/ready handshake, a two-stage pipeline, a round-half-up mode and a saturation event counter.

## Interface
- BW, default 8: operand width per lane; must be greater than MULT_DW.
- MULT_DW, default 5: multiplier datapath width; window width W = MULT_DW-2, with W ≥ 1.
- LANES, default 4: independent lanes per transaction.
- PW: localparam, equal to $clog2(BW); this is the position field width.
- clk  in  1  single clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  unit accepts the transaction this cycle.
- in_data  in  LANES*BW  operands; lane i is in_data[i*BW +: BW].
- in_rnd  in  1  round mode for this transaction; it travels with the data.
- out_valid  out  1  output transaction valid.
- out_ready  in  1  downstream accepts the output.
- out_mant  out  LANES*W  per-lane truncated window.
- out_pos  out  LANES*PW  per-lane leading-one position.
- out_exact  out  LANES  per-lane flag: the operand is small enough for the exact path.
- out_nz  out  LANES  per-lane flag: the operand is non-zero.
- sat_clr  in  1  synchronous clear of sat_count.
- sat_count  out  16  count of lanes that saturated on rounding overflow.

## Operation
- Per lane, with operand x: p is the index of the most significant 1 in x. nz = (x != 0).
- If x == 0: p = 0, mant = 0, exact = 1.
- If p < MULT_DW: mant = 0, pos = p, exact = 1. The exact path is handled downstream.
- If p ≥ MULT_DW: mant = x[p-1 -: W], pos = p, exact = 0. The leading one itself is implicit and is not included in mant.
- Round mode (in_rnd = 1), applied only when exact = 0:
  - Round bit r = x[p-1-W]. This index is always ≥ 1.
  - mant' = mant + r, computed at W+1 bits.
  - No carry out: use mant' as the result.
  - Carry out and p+1 < BW: mant = 0, pos = p+1.
  - Carry out and p+1 == BW: saturate to mant = all ones, pos = BW-1, and flag a saturation event.
- In_rnd = 0 gives pure truncation and never saturates.
- Stage A registers the operands, in_rnd, and the per-lane p, nz and exact values.
- Stage B computes the window and rounding and registers all out_* fields. The out_* ports are the stage B registers directly.
- sat_count increments by the number of lanes that saturated in a transaction. It is updated when that transaction is loaded into stage B.
  - It saturates at 0xFFFF and never wraps.
  - sat_clr has priority over any increment in the same cycle.

## Timing
- Reset: vA = vB = 0, out_valid = 0, and out_mant, out_pos, out_exact, out_nz and sat_count all 0.
  - in_ready = 1 during and immediately after reset.
  - Reset asserted mid-transfer discards all in-flight data at once; nothing is replayed.
- Advance conditions: advB = !vB | out_ready. advA = !vA | advB. in_ready = advA.
  - in_ready depends combinationally on out_ready; there is no combinational path from in_valid to in_ready.
- Stage A loads when in_valid & in_ready. Stage B loads from A when vA & advB.
  - vA clears when A drains into B and no new input arrives.
  - vB clears on out_ready when A is empty.
- Latency: 2 cycles from input acceptance to out_valid with no stall. Throughput is one transaction per cycle while out_ready = 1.
- Stall (out_valid & !out_ready):
  - out_* hold stable.
  - Stage A fills once, then in_ready drops.
  - No transaction is lost or duplicated.
- Simultaneous drain and refill is allowed in the same cycle on both stages.

## Test plan
- BW=8, MULT_DW=5, LANES=4, no rounding. Lanes 0xB6, 0x78, 0x13, 0x00 produce:
  - lane 0: mant 3'b011, pos 7, exact 0;
  - lane 1: mant 3'b111, pos 6, exact 0;
  - lane 2: mant 0, pos 4, exact 1;
  - lane 3: nz 0, exact 1, pos 0.
  - out_valid is asserted exactly 2 cycles after acceptance.
- Rounding on. Lanes 0xBE, 0x7C, 0xF8, 0x1F produce:
  - lane 0: mant 3'b100, pos 7;
  - lane 1: mant 0, pos 7 (carry into a new position);
  - lane 2: mant 3'b111, pos 7 (saturated);
  - lane 3: exact 1.
  - sat_count increments to 1.
- Back-to-back stream of 8 transactions with out_ready held at 1: 8 consecutive out_valid cycles, in order, with no bubbles.
- out_ready low for 5 cycles mid-stream:
  - in_ready drops after one extra acceptance;
  - outputs stay frozen;
  - the sequence resumes with no loss or duplication.
- Saturation counting: 0xFFFF saturating lanes, then one more saturating lane, leaves sat_count at 0xFFFF. sat_clr asserted in the same cycle as a saturation event leaves sat_count at 0.
- Reset: rst_n pulsed low with both stages full clears out_valid and sat_count immediately, asynchronously. The first input after reset appears 2 cycles after it is accepted.
